// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - multi-channel draw arbiter muxing one owner onto the VGA adapter port
// Round-robin or fixed-priority grant with optional hold limit and a registered pixel path.
module vga_draw_arbiter #(
  parameter int NUM_CH        = 12,
  parameter int X_W           = 8,
  parameter int Y_W           = 7,
  parameter int C_W           = 3,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_HOLD      = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*X_W-1:0] x_in,
  input  logic [NUM_CH*Y_W-1:0] y_in,
  input  logic [NUM_CH*C_W-1:0] colour_in,
  input  logic [NUM_CH-1:0]     writeEn_in,
  output logic [NUM_CH-1:0]     grant,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [C_W-1:0]        colour,
  output logic                  writeEn,
  output logic                  busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HC_W  = (MAX_HOLD == 0) ? 8 : $clog2(MAX_HOLD + 1);
  localparam logic [PTR_W-1:0]  LAST_CH   = PTR_W'(NUM_CH - 1);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [NUM_CH-1:0] ONE_HOT0  = NUM_CH'(1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t            state, next_state;
  logic [PTR_W-1:0]  ptr, owner, win, idx;
  logic [HC_W-1:0]   hold;
  logic              found, hold_expired, start, finish;

  // Search starts at ptr in round-robin mode, at 0 in fixed mode.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'(((PRIORITY_MODE == 1 ? 0 : int'(ptr)) + k) % NUM_CH);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hold_expired = (MAX_HOLD > 0) && (hold == HOLD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = GRANT;
      GRANT: begin
        if (!req[owner])       next_state = IDLE;
        else if (hold_expired) next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    start  = (state == IDLE) && found;
    finish = (state == GRANT) && (next_state != GRANT);
  end

  // Pixel path follows the grant currently registered, so it lags the inputs by one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant   <= '0;
      ptr     <= '0;
      owner   <= '0;
      hold    <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end else begin
      writeEn <= |(grant & writeEn_in);
      if (|grant) begin
        x      <= x_in[int'(owner)*X_W +: X_W];
        y      <= y_in[int'(owner)*Y_W +: Y_W];
        colour <= colour_in[int'(owner)*C_W +: C_W];
      end
      if (start) begin
        grant <= ONE_HOT0 << win;
        owner <= win;
        hold  <= '0;
      end else if (finish) begin
        grant <= '0;
        ptr   <= (owner == LAST_CH) ? '0 : owner + PTR_W'(1);
      end else if (state == GRANT && hold != '1) begin
        hold <= hold + HC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - directed self-checking bench for vga_draw_arbiter
// Three instances share stimulus: round-robin unlimited, fixed priority, round-robin with hold limit 4.
module tb_vga_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] req;
  logic [11:0] we;
  logic [95:0] x_in;
  logic [83:0] y_in;
  logic [35:0] c_in;

  logic [11:0] g_rr, g_fx, g_mh;
  logic [7:0]  x_rr, x_fx, x_mh;
  logic [6:0]  y_rr, y_fx, y_mh;
  logic [2:0]  c_rr, c_fx, c_mh;
  logic        w_rr, w_fx, w_mh;
  logic        b_rr, b_fx, b_mh;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vga_draw_arbiter u_rr (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(c_in), .writeEn_in(we), .grant(g_rr), .x(x_rr), .y(y_rr),
    .colour(c_rr), .writeEn(w_rr), .busy(b_rr)
  );

  vga_draw_arbiter #(.PRIORITY_MODE(1)) u_fx (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(c_in), .writeEn_in(we), .grant(g_fx), .x(x_fx), .y(y_fx),
    .colour(c_fx), .writeEn(w_fx), .busy(b_fx)
  );

  vga_draw_arbiter #(.MAX_HOLD(4)) u_mh (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(c_in), .writeEn_in(we), .grant(g_mh), .x(x_mh), .y(y_mh),
    .colour(c_mh), .writeEn(w_mh), .busy(b_mh)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
    x_in[i*8 +: 8] = xv;
    y_in[i*7 +: 7] = yv;
    c_in[i*3 +: 3] = cv;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic restart;
    req   = '0;
    we    = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    req  = '0;
    we   = '0;
    x_in = '0;
    y_in = '0;
    c_in = '0;

    #1 reset = 1'b1;
    #1;
    chk("rst_grant", g_rr, 0);
    chk("rst_busy", b_rr, 0);
    chk("rst_we", w_rr, 0);
    chk("rst_x", x_rr, 0);
    chk("rst_y", y_rr, 0);
    chk("rst_colour", c_rr, 0);
    tick();
    reset = 1'b0;

    // single channel burst
    set_ch(3, 8'd10, 7'd20, 3'd5);
    we[3]  = 1'b1;
    req[3] = 1'b1;
    tick();
    chk("s_grant", g_rr, 12'h008);
    chk("s_busy", b_rr, 1);
    chk("s_we_early", w_rr, 0);
    tick();
    chk("s_we", w_rr, 1);
    chk("s_x", x_rr, 10);
    chk("s_y", y_rr, 20);
    chk("s_colour", c_rr, 5);
    req[3] = 1'b0;
    tick();
    chk("s_drop", g_rr, 0);
    chk("s_idle_busy", b_rr, 0);

    // round-robin ordering and wrap
    restart();
    req[0] = 1'b1;
    req[5] = 1'b1;
    tick();
    chk("rr_first", g_rr, 12'h001);
    req[0] = 1'b0;
    tick();
    chk("rr_idle", g_rr, 0);
    tick();
    chk("rr_second", g_rr, 12'h020);
    req[0] = 1'b1;
    req[5] = 1'b0;
    tick();
    chk("rr_idle2", g_rr, 0);
    req[5] = 1'b1;
    tick();
    chk("rr_wrap", g_rr, 12'h001);

    // fixed priority
    restart();
    req[2] = 1'b1;
    req[7] = 1'b1;
    tick();
    chk("fx_first", g_fx, 12'h004);
    for (int r = 0; r < 3; r++) begin
      req[2] = 1'b0;
      tick();
      chk("fx_drop", g_fx, 0);
      req[2] = 1'b1;
      tick();
      chk("fx_regrant", g_fx, 12'h004);
      if (r == 0) chk("rr_vs_fx", g_rr, 12'h080);
    end
    req[2] = 1'b0;
    tick();
    chk("fx_drop_last", g_fx, 0);
    tick();
    chk("fx_ch7", g_fx, 12'h080);

    // hold limit of 4
    restart();
    req[1] = 1'b1;
    req[4] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mh_hold", g_mh, 12'h002);
    end
    tick();
    chk("mh_release", g_mh, 0);
    chk("mh_rel_busy", b_mh, 1);
    tick();
    chk("mh_idle", g_mh, 0);
    chk("mh_idle_busy", b_mh, 0);
    tick();
    chk("mh_next", g_mh, 12'h010);
    chk("rr_nolimit", g_rr, 12'h002);

    // non-owner isolation
    restart();
    set_ch(1, 8'd7, 7'd1, 3'd1);
    set_ch(6, 8'd99, 7'd2, 3'd2);
    we[6]  = 1'b1;
    req[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("iso_we", w_rr, 0);
      chk("iso_x", x_rr, (c == 0) ? 0 : 7);
    end

    // reset in the middle of a burst
    restart();
    set_ch(2, 8'd33, 7'd44, 3'd6);
    we[2]  = 1'b1;
    req[2] = 1'b1;
    tick();
    chk("mr_grant", g_rr, 12'h004);
    tick();
    chk("mr_we", w_rr, 1);
    chk("mr_x", x_rr, 33);
    #2 reset = 1'b1;
    #1;
    chk("mr_rst_grant", g_rr, 0);
    chk("mr_rst_we", w_rr, 0);
    chk("mr_rst_busy", b_rr, 0);
    chk("mr_rst_x", x_rr, 0);
    reset = 1'b0;
    tick();
    chk("mr_regrant", g_rr, 12'h004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
